abro_input_conditioner: RTL and testbench
=========================================

Name: abro_input_conditioner

Overview:
Upstream stage of ABROStateMachine. Takes three raw, asynchronous button/sensor lines (a_raw, b_raw, r_raw), synchronises and debounces each one, and produces single-cycle rising-edge pulses. The A and B pulses drive the state machine's A and B inputs. The R pulse drives its Reset input. Debounced levels are also exported for monitoring.

Parameters:
SYNC_STAGES, 2, synchroniser flop depth per channel; legal range is 2 or more.
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from the debounced level before that level changes; legal range is 1 to 2**CNT_W-1.
CNT_W, 3, width of each per-channel debounce counter.

Ports:
Clock  input  1  single system clock; all state updates on its rising edge.
Reset  input  1  synchronous, active-high; clears all state on the next rising edge of Clock.
a_raw  input  1  raw A line, asynchronous to Clock.
b_raw  input  1  raw B line, asynchronous to Clock.
r_raw  input  1  raw R (restart) line, asynchronous to Clock.
A      output 1  one-cycle pulse on each debounced rising edge of a_raw.
B      output 1  one-cycle pulse on each debounced rising edge of b_raw.
R      output 1  one-cycle pulse on each debounced rising edge of r_raw.
A_level output 1  debounced level of a_raw.
B_level output 1  debounced level of b_raw.
R_level output 1  debounced level of r_raw.

Behaviour:
- Three identical, independent channels (A, B, R). There is no cross-channel interaction.
- Per-channel state: sync chain [SYNC_STAGES], debounced level lvl, counter cnt [CNT_W], pulse register.
- Reset: every sync flop, lvl, cnt and pulse is set to 0. All six outputs are 0 on the cycle after the Reset edge and stay 0 while Reset is held.
- Sync: sync[0] <= raw; sync[i] <= sync[i-1]. The output s = sync[SYNC_STAGES-1].
- Debounce, evaluated every edge when Reset=0:
  - if s == lvl: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: lvl <= s and cnt <= 0.
  - else: cnt <= cnt+1.
- Pulse: pulse <= 1 exactly on the edge where lvl goes 0 -> 1; otherwise pulse <= 0. All outputs are registered.
  - A 1 -> 0 change of lvl produces no pulse.
  - The pulse width is always exactly 1 cycle, even if the raw line is held high indefinitely.
- Latency: raw changes before edge 1 and is then held stable.
  - s reflects it after edge SYNC_STAGES.
  - lvl and the pulse rise after edge SYNC_STAGES+DEBOUNCE_CYCLES (6 with defaults).
  - The pulse falls after the next edge.
- Glitch rejection: if s returns to lvl before the counter completes, cnt clears to 0 and lvl is unchanged. The next disagreement restarts the count from 0.
- DEBOUNCE_CYCLES=1: lvl follows s with one cycle of delay and no filtering.
- Simultaneous rising edges on several channels: each channel pulses independently, so the pulses may coincide in the same cycle.
- Reset mid-count: cnt and lvl clear, and any pending transition is discarded.
- Raw held high across Reset: after Reset deasserts, the line is treated as a fresh 0 -> 1 transition. Level and pulse appear SYNC_STAGES+DEBOUNCE_CYCLES edges after the first edge with Reset=0.
- Reset asserted on the same edge a pulse would fire: Reset wins and the pulse stays 0.
- The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Test Plan:
1. Reset=1 for 2 cycles with all raw lines at 1 -> all outputs 0. Release Reset -> A, B, R and their levels rise after edge 6 (counting from the first edge with Reset=0). A, B, R fall after edge 7, and the levels stay 1.
2. a_raw high for 3 cycles then low (defaults) -> A_level and A stay 0 throughout. a_raw high for 5 cycles -> A_level=1 after edge 6 and exactly one A pulse.
3. b_raw toggling every cycle for 20 cycles -> B and B_level stay 0. b_raw then held high -> a single B pulse 6 edges later.
4. a_raw and b_raw rise at the same sampling edge -> A and B pulse in the same cycle. Drop a_raw -> A_level falls 6 edges later and no A pulse occurs.
5. r_raw high for 4 cycles, then Reset pulsed for 1 cycle while r_raw stays high -> no R pulse before Reset. After release, one R pulse 6 edges later.
6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3 -> a 1-cycle a_raw glitch gives A_level high for 1 cycle and one A pulse, both appearing after edge 4.

Source files
------------

// File: rtl/abro_input_conditioner.sv
// Front end for the ABRO state machine: each of the three raw lines (A, B, R) is
// synchronised, debounced and turned into a one-cycle rising-edge pulse.
module abro_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 3
) (
    input  logic Clock,
    input  logic Reset,
    input  logic a_raw,
    input  logic b_raw,
    input  logic r_raw,
    output logic A,
    output logic B,
    output logic R,
    output logic A_level,
    output logic B_level,
    output logic R_level
);

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned CH_A   = 0;
    localparam int unsigned CH_B   = 1;
    localparam int unsigned CH_R   = 2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_CH-1:0]      raw_c;
    logic [NUM_CH-1:0]      sync_out_c;

    logic [SYNC_STAGES-1:0] sync_q [NUM_CH];
    logic [SYNC_STAGES-1:0] sync_d [NUM_CH];
    logic [CNT_W-1:0]       cnt_q  [NUM_CH];
    logic [CNT_W-1:0]       cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]      lvl_q;
    logic [NUM_CH-1:0]      lvl_d;
    logic [NUM_CH-1:0]      pulse_q;
    logic [NUM_CH-1:0]      pulse_d;

    assign raw_c = {r_raw, b_raw, a_raw};

    // Synchroniser shift: stage 0 samples the raw line, the last stage feeds the debouncer.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            sync_d[i]     = {sync_q[i][SYNC_STAGES-2:0], raw_c[i]};
            sync_out_c[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive disagreements;
    // any agreement clears the count so a glitch restarts the qualification from zero.
    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            lvl_d[i] = lvl_q[i];
            cnt_d[i] = cnt_q[i];
            if (sync_out_c[i] == lvl_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                lvl_d[i] = sync_out_c[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
    end

    // Pulse only on a 0 -> 1 move of the debounced level.
    always_comb begin
        pulse_d = lvl_d & ~lvl_q;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            lvl_q   <= '0;
            pulse_q <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                sync_q[i] <= sync_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            lvl_q   <= lvl_d;
            pulse_q <= pulse_d;
        end
    end

    assign A       = pulse_q[CH_A];
    assign B       = pulse_q[CH_B];
    assign R       = pulse_q[CH_R];
    assign A_level = lvl_q[CH_A];
    assign B_level = lvl_q[CH_B];
    assign R_level = lvl_q[CH_R];

endmodule

// File: tb/tb_abro_input_conditioner.sv
// Directed bench for abro_input_conditioner: default instance plus a
// DEBOUNCE_CYCLES=1 / SYNC_STAGES=3 instance for the unfiltered case.
module tb_abro_input_conditioner;

    logic Clock = 1'b0;
    logic Reset;
    logic a_raw, b_raw, r_raw;
    logic A, B, R, A_level, B_level, R_level;
    logic a1_raw, b1_raw, r1_raw;
    logic A1, B1, R1, A1_level, B1_level, R1_level;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    abro_input_conditioner dut (
        .Clock(Clock), .Reset(Reset),
        .a_raw(a_raw), .b_raw(b_raw), .r_raw(r_raw),
        .A(A), .B(B), .R(R),
        .A_level(A_level), .B_level(B_level), .R_level(R_level)
    );

    abro_input_conditioner #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .CNT_W(3)) dut1 (
        .Clock(Clock), .Reset(Reset),
        .a_raw(a1_raw), .b_raw(b1_raw), .r_raw(r1_raw),
        .A(A1), .B(B1), .R(R1),
        .A_level(A1_level), .B_level(B1_level), .R_level(R1_level)
    );

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Vector order: {A, B, R, A_level, B_level, R_level}
    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] v0();
        return {A, B, R, A_level, B_level, R_level};
    endfunction

    function automatic logic [5:0] v1();
        return {A1, B1, R1, A1_level, B1_level, R1_level};
    endfunction

    initial begin
        logic [5:0] e;
        Reset = 1'b1;
        a_raw = 1'b1; b_raw = 1'b1; r_raw = 1'b1;
        a1_raw = 1'b0; b1_raw = 1'b0; r1_raw = 1'b0;

        // 1. Reset with all lines high, then fresh transition after release
        step(); step();
        chk("reset_hold", v0(), 6'b000_000);
        chk("reset_hold_dut1", v1(), 6'b000_000);
        Reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k < 6) ? 6'b000_000 : (k == 6) ? 6'b111_111 : 6'b000_111;
            chk($sformatf("post_reset_k%0d", k), v0(), e);
        end

        // Drop everything and let levels fall with no pulses
        a_raw = 1'b0; b_raw = 1'b0; r_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k < 6) ? 6'b000_111 : 6'b000_000;
            chk($sformatf("fall_all_k%0d", k), v0(), e);
        end

        // 2a. 3-cycle glitch on a_raw is rejected
        a_raw = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) a_raw = 1'b0;
            step();
            chk($sformatf("a_glitch3_k%0d", k), v0(), 6'b000_000);
            if (k == 3) a_raw = 1'b0;
        end

        // 2b. 5-cycle a_raw high qualifies: one pulse, level 6..10
        a_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 5) a_raw = 1'b0;
            e = 6'b000_000;
            if (k >= 6 && k <= 10) e[2] = 1'b1;
            if (k == 6) e[5] = 1'b1;
            chk($sformatf("a_high5_k%0d", k), v0(), e);
        end

        // 3. b_raw toggling every cycle never qualifies
        for (int k = 0; k < 20; k++) begin
            b_raw = (k % 2 == 0);
            step();
            chk($sformatf("b_toggle_k%0d", k), v0(), 6'b000_000);
        end
        b_raw = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            e = (k < 6) ? 6'b000_000 : (k == 6) ? 6'b010_010 : 6'b000_010;
            chk($sformatf("b_hold_k%0d", k), v0(), e);
        end

        // Release B, falling level must not pulse
        b_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k < 6) ? 6'b000_010 : 6'b000_000;
            chk($sformatf("b_fall_k%0d", k), v0(), e);
        end

        // 4. A and B rise together -> coincident pulses
        a_raw = 1'b1; b_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k < 6) ? 6'b000_000 : (k == 6) ? 6'b110_110 : 6'b000_110;
            chk($sformatf("ab_rise_k%0d", k), v0(), e);
        end
        a_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k < 6) ? 6'b000_110 : 6'b000_010;
            chk($sformatf("a_drop_k%0d", k), v0(), e);
        end

        // 5. r_raw high 4 cycles, Reset pulsed mid-count, then fresh transition
        r_raw = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("r_pre_k%0d", k), v0(), 6'b000_010);
        end
        Reset = 1'b1;
        step();
        chk("r_reset_pulse", v0(), 6'b000_000);
        Reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e = (k < 6) ? 6'b000_000 : (k == 6) ? 6'b011_011 : 6'b000_011;
            chk($sformatf("r_after_reset_k%0d", k), v0(), e);
        end

        // Reset on the edge where the pulse would fire: Reset wins
        b_raw = 1'b0; r_raw = 1'b0;
        for (int k = 1; k <= 8; k++) step();
        chk("settle_low", v0(), 6'b000_000);
        a_raw = 1'b1;
        for (int k = 1; k <= 5; k++) step();
        chk("pre_fire", v0(), 6'b000_000);
        Reset = 1'b1;
        step();
        chk("reset_wins", v0(), 6'b000_000);
        Reset = 1'b0;
        a_raw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("after_reset_wins_k%0d", k), v0(), 6'b000_000);
        end

        // 6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3: 1-cycle glitch passes after edge 4
        a1_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step();
            a1_raw = 1'b0;
            e = (k == 4) ? 6'b100_100 : 6'b000_000;
            chk($sformatf("dut1_glitch_k%0d", k), v1(), e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
